// File: rtl/mm_seq_ctrl.sv
// mm_seq_ctrl: skewed-feed sequencer for an NxN output-stationary PE array
module mm_seq_ctrl #(
  parameter int N = 3,
  parameter int DW = 4,
  parameter int OW = 9,
  parameter int PIPE = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*N*DW-1:0]   in1,
  input  logic [N*N*DW-1:0]   in2,
  output logic                pe_clr,
  output logic                pe_en,
  output logic [N*DW-1:0]     a_feed,
  output logic [N*DW-1:0]     b_feed,
  input  logic [N*N*OW-1:0]   res_in,
  output logic [N*N*OW-1:0]   out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);
  localparam int KW = $clog2(3*N-1);
  localparam int PW = $clog2(PIPE+2);
  localparam logic [KW-1:0] KL = KW'(3*N-3);
  localparam logic [PW-1:0] DL = PW'(PIPE-1);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
  state_t st, nxt;
  logic [KW-1:0] k;
  logic [PW-1:0] d;
  logic [N*N*DW-1:0] a_q, b_q;
  logic cap;
  assign in_ready = en & (st == IDLE);
  assign pe_clr = en & (st == CLEAR);
  assign pe_en = en & (st == FEED | st == DRAIN);
  assign busy = st != IDLE;
  assign cap = en & ((st == FEED & k == KL & PIPE == 0) | (st == DRAIN & d == DL));
  always_comb begin
    nxt = st;
    if (en)
      case (st)
        IDLE:    nxt = in_valid ? CLEAR : IDLE;
        CLEAR:   nxt = FEED;
        FEED:    nxt = k != KL ? FEED : PIPE == 0 ? DONE : DRAIN;
        DRAIN:   nxt = d == DL ? DONE : DRAIN;
        DONE:    nxt = out_ready ? IDLE : DONE;
        default: nxt = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) st <= IDLE;
    else st <= nxt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k <= '0;
      d <= '0;
      a_q <= '0;
      b_q <= '0;
      out <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      k <= st == FEED ? k + 1'b1 : '0;
      d <= st == DRAIN ? d + 1'b1 : '0;
      if (in_valid & in_ready) begin
        a_q <= in1;
        b_q <= in2;
      end
      if (cap) out <= res_in;
      out_valid <= nxt == DONE;
    end
  end
  // row r sees A[r][k-r], column c sees B[k-c][c]; zero outside the diagonal band
  always_comb begin
    a_feed = '0;
    b_feed = '0;
    for (int r = 0; r < N; r++)
      if (st == FEED && int'(k) >= r && int'(k) - r < N) begin
        a_feed[r*DW +: DW] = a_q[(r*N + int'(k) - r)*DW +: DW];
        b_feed[r*DW +: DW] = b_q[((int'(k) - r)*N + r)*DW +: DW];
      end
  end
endmodule

// File: tb/tb_mm_seq_ctrl.sv
// tb_mm_seq_ctrl: directed bench with a behavioural systolic array behind the sequencer
module tb_mm_seq_ctrl;
  localparam int N = 3, DW = 4, OW = 9, PIPE = 2;
  localparam logic [35:0] MA = 36'h987654321;
  localparam logic [35:0] MI = 36'h100010001;
  localparam logic [35:0] M2I = 36'h200020002;
  logic clk = 1'b0, rst, en, in_valid, in_ready, pe_clr, pe_en, out_valid, out_ready, busy;
  logic [N*N*DW-1:0] in1, in2;
  logic [N*DW-1:0] a_feed, b_feed;
  logic [N*N*OW-1:0] res_in, out;
  int total = 0, bad = 0;
  mm_seq_ctrl #(.N(N), .DW(DW), .OW(OW), .PIPE(PIPE)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .pe_clr(pe_clr), .pe_en(pe_en), .a_feed(a_feed),
    .b_feed(b_feed), .res_in(res_in), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );
  always #5 clk = ~clk;
  logic [OW-1:0] acc [N][N];
  logic [DW-1:0] ar [N][N], br [N][N];
  logic [DW-1:0] at [N][N+1], bt [N+1][N];
  always_comb begin
    for (int i = 0; i < N; i++) begin
      at[i][0] = a_feed[i*DW +: DW];
      bt[0][i] = b_feed[i*DW +: DW];
      for (int j = 0; j < N; j++) begin
        at[i][j+1] = ar[i][j];
        bt[i+1][j] = br[i][j];
        res_in[(i*N+j)*OW +: OW] = acc[i][j];
      end
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (pe_clr) begin
          acc[i][j] <= '0;
          ar[i][j] <= '0;
          br[i][j] <= '0;
        end else if (pe_en) begin
          acc[i][j] <= acc[i][j] + OW'(at[i][j]) * OW'(bt[i][j]);
          ar[i][j] <= at[i][j];
          br[i][j] <= bt[i][j];
        end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic start_op(input logic [35:0] a, input logic [35:0] b);
    int n = 0;
    in1 = a;
    in2 = b;
    in_valid = 1'b1;
    while (!in_ready && n < 40) begin
      tick;
      n++;
    end
    total++;
    if (n >= 40) begin bad++; $display("FAIL accept_timeout got=%0d want<40", n); end
    tick;
    in_valid = 1'b0;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick;
      n++;
    end
  endtask
  task automatic consume;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b0;
    en = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in1 = '0;
    in2 = '0;
    #2;
    total++; if (out !== '0) begin bad++; $display("FAIL rst_out got=%h want=0", out); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (pe_clr !== 1'b0) begin bad++; $display("FAIL rst_pe_clr got=%b want=0", pe_clr); end
    total++; if (pe_en !== 1'b0) begin bad++; $display("FAIL rst_pe_en got=%b want=0", pe_en); end
    total++; if (a_feed !== '0) begin bad++; $display("FAIL rst_a_feed got=%h want=0", a_feed); end
    total++; if (b_feed !== '0) begin bad++; $display("FAIL rst_b_feed got=%h want=0", b_feed); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready_en1 got=%b want=1", in_ready); end
    en = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready_en0 got=%b want=0", in_ready); end
    en = 1'b1;
    tick;
    rst = 1'b1;
    tick;
  endtask
  task automatic test_feed;
    logic [11:0] fa [7] = '{12'h001, 12'h042, 12'h753, 12'h860, 12'h900, 12'h000, 12'h000};
    logic [11:0] fb [7] = '{12'h001, 12'h024, 12'h357, 12'h680, 12'h900, 12'h000, 12'h000};
    int e [9] = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
    logic [N*N*OW-1:0] o;
    int n;
    start_op(MA, MA);
    in1 = '1;
    in2 = '1;
    total++; if (pe_clr !== 1'b1) begin bad++; $display("FAIL clear_pe_clr got=%b want=1", pe_clr); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL clear_in_ready got=%b want=0", in_ready); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL clear_busy got=%b want=1", busy); end
    tick;
    for (int k = 0; k < 7; k++) begin
      total++; if (a_feed !== fa[k]) begin bad++; $display("FAIL a_feed_k%0d got=%h want=%h", k, a_feed, fa[k]); end
      total++; if (b_feed !== fb[k]) begin bad++; $display("FAIL b_feed_k%0d got=%h want=%h", k, b_feed, fb[k]); end
      total++; if (pe_en !== 1'b1) begin bad++; $display("FAIL feed_pe_en_k%0d got=%b want=1", k, pe_en); end
      tick;
    end
    total++; if (pe_en !== 1'b1 || a_feed !== '0) begin bad++; $display("FAIL drain_state got=%b/%h want=1/0", pe_en, a_feed); end
    wait_valid(n);
    total++; if (n !== 2) begin bad++; $display("FAIL latency_tail got=%0d want=2", n); end
    for (int i = 0; i < 9; i++) begin
      total++; if (out[i*OW +: OW] !== OW'(e[i])) begin bad++; $display("FAIL axa_%0d got=%0d want=%0d", i, out[i*OW +: OW], e[i]); end
    end
    o = out;
    repeat (2) tick;
    total++; if (out_valid !== 1'b1 || out !== o) begin bad++; $display("FAIL done_hold got=%b/%h want=1/%h", out_valid, out, o); end
    consume;
    in1 = '0;
    in2 = '0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL consumed_valid got=%b want=0", out_valid); end
    total++; if (out !== o) begin bad++; $display("FAIL out_keeps got=%h want=%h", out, o); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b want=1", in_ready); end
  endtask
  task automatic test_stall;
    int n;
    start_op(MA, MI);
    repeat (3) tick;
    total++; if (a_feed !== 12'h753 || b_feed !== 12'h010) begin bad++; $display("FAIL stall_pre got=%h/%h want=753/010", a_feed, b_feed); end
    en = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      total++; if (pe_en !== 1'b0) begin bad++; $display("FAIL stall_pe_en_%0d got=%b want=0", s, pe_en); end
      total++; if (a_feed !== 12'h753 || b_feed !== 12'h010) begin bad++; $display("FAIL stall_feed_%0d got=%h/%h want=753/010", s, a_feed, b_feed); end
      total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL stall_ctl_%0d got=%b/%b want=0/0", s, in_ready, out_valid); end
      tick;
    end
    en = 1'b1;
    wait_valid(n);
    total++; if (n !== 7) begin bad++; $display("FAIL stall_latency got=%0d want=7", n); end
    for (int i = 0; i < 9; i++) begin
      total++; if (out[i*OW +: OW] !== OW'(i + 1)) begin bad++; $display("FAIL axi_%0d got=%0d want=%0d", i, out[i*OW +: OW], i + 1); end
    end
    consume;
  endtask
  task automatic test_abort;
    int n;
    start_op(MA, MA);
    repeat (5) tick;
    total++; if (a_feed !== 12'h900) begin bad++; $display("FAIL abort_pre got=%h want=900", a_feed); end
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || pe_en !== 1'b0 || a_feed !== '0) begin bad++; $display("FAIL abort_ctl got=%b/%b/%h want=0/0/0", busy, pe_en, a_feed); end
    total++; if (out_valid !== 1'b0 || out !== '0) begin bad++; $display("FAIL abort_out got=%b/%h want=0/0", out_valid, out); end
    #2;
    rst = 1'b1;
    tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_no_valid got=%b want=0", out_valid); end
    start_op(MA, M2I);
    total++; if (pe_clr !== 1'b1) begin bad++; $display("FAIL restart_clr got=%b want=1", pe_clr); end
    tick;
    total++; if (a_feed !== 12'h001 || b_feed !== 12'h002) begin bad++; $display("FAIL restart_k0 got=%h/%h want=001/002", a_feed, b_feed); end
    wait_valid(n);
    total++; if (n !== 9) begin bad++; $display("FAIL restart_latency got=%0d want=9", n); end
    for (int i = 0; i < 9; i++) begin
      total++; if (out[i*OW +: OW] !== OW'(2 * (i + 1))) begin bad++; $display("FAIL ax2i_%0d got=%0d want=%0d", i, out[i*OW +: OW], 2 * (i + 1)); end
    end
    consume;
  endtask
  task automatic test_back_to_back;
    int first = -1, second = -1, viol = 0, n = 0;
    out_ready = 1'b1;
    in1 = MA;
    in2 = MA;
    in_valid = 1'b1;
    for (int e = 0; e < 30; e++) begin
      if (in_ready) begin
        if (first < 0) first = e;
        else if (second < 0) second = e;
      end
      if (busy && in_ready) viol++;
      tick;
    end
    in_valid = 1'b0;
    total++; if (first !== 0) begin bad++; $display("FAIL b2b_first got=%0d want=0", first); end
    total++; if (second - first !== 12) begin bad++; $display("FAIL b2b_spacing got=%0d want=12", second - first); end
    total++; if (viol !== 0) begin bad++; $display("FAIL b2b_ready_busy got=%0d want=0", viol); end
    while (busy && n < 40) begin
      tick;
      n++;
    end
    out_ready = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", busy); end
  endtask
  task automatic test_hold;
    logic [N*N*OW-1:0] o;
    int n;
    start_op(MA, MI);
    wait_valid(n);
    total++; if (n !== 10) begin bad++; $display("FAIL hold_latency got=%0d want=10", n); end
    o = out;
    in1 = '0;
    in2 = '0;
    in_valid = 1'b1;
    for (int s = 0; s < 5; s++) begin
      total++; if (out_valid !== 1'b1 || out !== o) begin bad++; $display("FAIL hold_%0d got=%b/%h want=1/%h", s, out_valid, out, o); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_ready_%0d got=%b want=0", s, in_ready); end
      tick;
    end
    in_valid = 1'b0;
    total++; if (out[8*OW +: OW] !== 9'd9) begin bad++; $display("FAIL hold_val got=%0d want=9", out[8*OW +: OW]); end
    consume;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL hold_exit got=%b/%b want=0/0", out_valid, busy); end
    tick;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_no_new got=%b want=0", busy); end
  endtask
  initial begin
    test_reset;
    test_feed;
    test_stall;
    test_abort;
    test_back_to_back;
    test_hold;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
